// File: rtl/qosc_sample_streamer.sv
// qosc_sample_streamer
// Decimates the quadrature oscillator's signed 16-bit I/Q outputs, buffers the
// captured {re, im} pairs in a small FIFO and serializes each pair as four
// bytes (re hi, re lo, im hi, im lo) on an 8-bit valid/ready port.
module qosc_sample_streamer #(
    parameter int DECIM = 8,   // capture one pair every DECIM enabled cycles (1..256)
    parameter int DEPTH = 4    // FIFO entries, power of 2, at least 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              accu_re,
    input  logic [15:0]              accu_im,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     frame_start,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int AW  = $clog2(DEPTH);                      // pointer width
    localparam int LW  = AW + 1;                             // level width (0..DEPTH)
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;    // decimation counter width

    localparam logic [DCW-1:0] DCNT_LAST  = DCW'(DECIM - 1);
    localparam logic [LW-1:0]  LEVEL_FULL = LW'(DEPTH);

    // Serializer states: IDLE, then one state per byte of the pair.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_B3
    } state_e;

    // ------------------------------------------------------------------
    // Decimation counter
    // ------------------------------------------------------------------
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;
    logic           capture;

    // Capture on the last count of an enabled run; any idle cycle restarts the count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dcnt_d  = '0;
        capture = en && (dcnt_q == DCNT_LAST);
        if (en && !capture) begin
            dcnt_d = dcnt_q + DCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [31:0]   head;
    logic          push;
    logic          pop;
    logic          drop;
    logic          overflow_q;

    state_e        state_q;
    logic [31:0]   hold_q;
    logic          valid_q;
    logic          frame_start_q;

    assign head = mem_q[rd_ptr_q];

    // The serializer pops when it is idle, or when the last byte of the
    // current pair transfers; in B3 byte_valid is always 1, so byte_ready
    // alone marks the transfer.
    always_comb begin
        pop = (level_q != '0) &&
              ((state_q == ST_IDLE) || ((state_q == ST_B3) && byte_ready));
    end

    // A capture is accepted if there is room, or if a pop frees a slot on the same edge.
    always_comb begin
        push = capture && ((level_q < LEVEL_FULL) || pop);
        drop = capture && !push;
    end

    // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Counter, pointers, level and the sticky drop flag.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            dcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Pair storage written at the write pointer on an accepted capture.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; pointers and level decide which entries are live.
        if (push) begin
            mem_q[wr_ptr_q] <= {accu_re, accu_im};
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    // The holding register shifts left by one byte per transfer, so its top
    // byte is always the byte on the port; after the fourth shift it is zero,
    // which is exactly the idle value of byte_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pop) begin
            // Load the next pair from IDLE or straight out of B3, with no bubble.
            state_q       <= ST_B0;
            hold_q        <= head;
            valid_q       <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q       <= 1'b0;
                    frame_start_q <= 1'b0;
                end
                ST_B0: begin
                    if (byte_ready) begin
                        state_q       <= ST_B1;
                        hold_q        <= {hold_q[23:0], 8'h00};
                        frame_start_q <= 1'b0;
                    end
                end
                ST_B1: begin
                    if (byte_ready) begin
                        state_q <= ST_B2;
                        hold_q  <= {hold_q[23:0], 8'h00};
                    end
                end
                ST_B2: begin
                    if (byte_ready) begin
                        state_q <= ST_B3;
                        hold_q  <= {hold_q[23:0], 8'h00};
                    end
                end
                ST_B3: begin
                    // Last byte gone and nothing queued: fall back to IDLE.
                    if (byte_ready) begin
                        state_q <= ST_IDLE;
                        hold_q  <= {hold_q[23:0], 8'h00};
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    hold_q        <= '0;
                    valid_q       <= 1'b0;
                    frame_start_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all straight from registers
    // ------------------------------------------------------------------
    assign byte_out    = hold_q[31:24];
    assign byte_valid  = valid_q;
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;
    assign fifo_level  = level_q;

endmodule

// File: doc/qosc_sample_streamer.md
# qosc_sample_streamer

Downstream stage of `quadrature_oscillator_sync`. It decimates the oscillator's signed 16-bit `accu_re`/`accu_im` outputs and buffers the captured I/Q pairs in a small FIFO. Each pair is serialized as four bytes on an 8-bit valid/ready output port, so the waveform can leave the chip through the narrow user I/O. It sits between the oscillator core and the top-level output pins.

## Interface
- `DECIM`, 8: capture one pair every `DECIM` enabled cycles; legal range 1..256.
- `DEPTH`, 4: FIFO entries, each holding one {re, im} pair; power of 2, at least 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: capture enable.
- `accu_re` in 16: signed real sample from the oscillator.
- `accu_im` in 16: signed imaginary sample from the oscillator.
- `byte_out` out 8: serialized data byte.
- `byte_valid` out 1: `byte_out` holds a valid byte.
- `byte_ready` in 1: consumer accepts the byte.
- `frame_start` out 1: high while the first byte of a pair is presented.
- `overflow` out 1: sticky flag; a captured pair was dropped.
- `fifo_level` out $clog2(DEPTH)+1: number of occupied FIFO entries (excludes the pair being serialized).

## Operation
- **Decimation counter `dcnt`:**
  - Runs 0..DECIM-1 while `en`=1 and wraps to 0.
  - Forced to 0 on any cycle with `en`=0.
  - Capture happens on an edge where `en`=1 and `dcnt`=DECIM-1.
  - With DECIM=1, capture occurs on every enabled edge.
- **Capture:** pushes {`accu_re`, `accu_im`} as sampled on that edge. Samples are stored raw, with no scaling or sign change.
- **Push acceptance:**
  - The push is accepted if `fifo_level` < DEPTH, or if a pop occurs on the same edge.
  - Otherwise the pair is dropped and `overflow` is set to 1. It stays 1 until `rst`.
- **FSM states:** IDLE, B0, B1, B2, B3.
- **IDLE:**
  - `byte_valid`=0, `byte_out`=0, `frame_start`=0.
  - If the FIFO is non-empty, pop the head into a 32-bit holding register and go to B0.
- **B0..B3:**
  - `byte_valid`=1.
  - Byte order: B0 = re[15:8], B1 = re[7:0], B2 = im[15:8], B3 = im[7:0].
  - `frame_start`=1 only in B0.
- **Advance:** a transfer is `byte_valid` & `byte_ready` on an edge; it advances Bn to Bn+1.
- **Leaving B3 on a transfer:**
  - If the FIFO is non-empty, pop the next pair and go directly to B0, with no bubble.
  - Otherwise go to IDLE.
- **Backpressure:** while `byte_valid`=1 and `byte_ready`=0, `byte_out` and `frame_start` hold stable.
- **Simultaneous push and pop:** the level is unchanged. Data order is strict FIFO order.
- **Reset:**
  - FIFO emptied, `dcnt`=0, FSM to IDLE, holding register cleared.
  - All outputs are 0 in the cycle after the `rst` edge: `byte_out`, `byte_valid`, `frame_start`, `overflow`, `fifo_level`.
  - Reset mid-frame abandons the frame; no partial bytes are emitted afterward.
  - `rst` has priority over capture and transfer on the same edge.

## Timing
- All outputs are registered.
- **Capture to first byte:** capture at edge E makes `fifo_level` increment after E. IDLE pops at E+1, so `byte_valid`=1 and `frame_start`=1 are visible after E+1. Latency is 2 clocks.
- **Throughput:** with `byte_ready` held high, one byte per clock and one frame per 4 clocks.
- **Rate limit:** with DECIM < 4 and continuous `en`, the FIFO fills and `overflow` is eventually set. This is required behaviour.
- **Level timing:** `fifo_level` updates one edge after the push or pop that caused the change.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `en`=1 and `byte_ready`=1 → `byte_out`=0, `byte_valid`=0, `frame_start`=0, `overflow`=0, `fifo_level`=0 after the first `rst` edge. No capture while `rst` is asserted.
- **Basic stream:**
  - Stimulus: DECIM=8, `en`=1, `accu_re`=16'h0020, `accu_im`=16'h0000, `byte_ready`=1.
  - Bytes 00, 20, 00, 00 appear on consecutive cycles, with `frame_start` only on 00(re hi).
  - First `byte_valid` is 2 clocks after the 8th enabled edge; frames repeat every 8 clocks; `fifo_level` never exceeds 1.
- **Sign and byte order:** `accu_re`=16'hFFFF (−1), `accu_im`=16'h8000 → bytes FF, FF, 80, 00.
- **Backpressure and overflow:**
  - Stimulus: DECIM=2, `byte_ready`=0 for 30 cycles.
  - `byte_out` is stable on the first byte; `fifo_level` saturates at 4; the next capture sets `overflow`=1.
  - After raising `byte_ready`: 5 frames (the held pair plus 4 FIFO entries) emerge back-to-back in capture order. `overflow` stays 1.
- **Enable gaps:** DECIM=4, `en` pattern 1,1,1,0,1,1,1,1 → no capture at the 3rd cycle; a capture occurs only after 4 consecutive enabled cycles following the gap.
- **Reset mid-frame:** after the B1 byte transfers, pulse `rst` for 1 cycle → `byte_valid`=0 the next cycle, `fifo_level`=0, `overflow` cleared. The stream restarts with a fresh B0 after the next capture.
